ita_mask_scheduler: RTL and testbench

Sequences the QK-step iteration space for the attention masking datapath. After a config handshake it drives a one-cycle init phase, then walks the counters in a fixed nest: count, then inner tile, then tile_x, then tile_y. The walked values are the count, tile_x, tile_y, last_inner_tile and calc_en inputs the masking unit consumes. It sits between the ITA controller and the masking unit, and stalls on downstream backpressure.

---
 rtl/ita_package.sv | 32 +++
 rtl/ita_wrap_counter.sv | 39 +++
 rtl/ita_mask_scheduler.sv | 143 ++++++++++++++
 tb/tb_ita_mask_scheduler.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ita_package.sv
// Shared types and constants for the ITA attention-mask scheduling path.
package ita_package;

  localparam int unsigned M              = 64;
  localparam int unsigned N              = 16;
  localparam int unsigned CNT_W          = 16;
  localparam int unsigned BEATS_PER_TILE = M * M / N;

  typedef logic [CNT_W-1:0] counter_t;

  typedef enum logic [1:0] {
    Idle,
    QK,
    AV,
    OW
  } step_e;

  typedef enum logic [1:0] {
    None,
    UpperTriangular,
    LowerTriangular,
    Strided
  } mask_e;

  typedef enum logic [1:0] {
    StIdle,
    StInit,
    StRun,
    StDone
  } sched_state_e;

endpackage

// File: rtl/ita_wrap_counter.sv
// Up-counter that wraps at a runtime maximum and flags the wrapping beat.
module ita_wrap_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [Width-1:0] max_i,
  output logic [Width-1:0] value_o,
  output logic             wrap_o
);

  logic [Width-1:0] value_d, value_q;

  // Wrap fires only on an enabled beat at the maximum, so it can enable the next level.
  assign wrap_o  = en_i && (value_q == max_i);
  assign value_o = value_q;

  // Next value: clear wins, otherwise increment with wrap to zero.
  always_comb begin
    value_d = value_q;
    if (clear_i) begin
      value_d = '0;
    end else if (en_i) begin
      value_d = (value_q == max_i) ? '0 : value_q + Width'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/ita_mask_scheduler.sv
// Walks the QK iteration space (count, inner, tile_x, tile_y) for the masking unit.
module ita_mask_scheduler
  import ita_package::*;
#(
  parameter int unsigned M     = ita_package::M,
  parameter int unsigned N     = ita_package::N,
  parameter int unsigned CNT_W = ita_package::CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [CNT_W-1:0] cfg_tile_s_i,
  input  logic [CNT_W-1:0] cfg_tile_inner_i,
  input  mask_e            cfg_mask_type_i,
  input  logic [CNT_W-1:0] cfg_mask_start_i,
  input  logic             out_ready_i,
  output step_e            step_o,
  output logic             calc_en_o,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] tile_x_o,
  output logic [CNT_W-1:0] tile_y_o,
  output logic             last_inner_tile_o,
  output mask_e            mask_type_o,
  output logic [CNT_W-1:0] mask_start_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned      Beats    = M * M / N;
  localparam logic [CNT_W-1:0] CountMax = CNT_W'(Beats - 1);

  sched_state_e     state_d, state_q;
  logic [CNT_W-1:0] tile_s_q, tile_inner_q;
  mask_e            mask_type_q;
  logic [CNT_W-1:0] mask_start_q;

  logic             accept, run_beat;
  logic [CNT_W-1:0] inner;
  logic             count_wrap, inner_wrap, tx_wrap, ty_wrap;

  assign accept   = (state_q == StIdle) && cfg_valid_i;
  assign run_beat = (state_q == StRun) && out_ready_i;

  // Config latch; zero tile counts are clamped to one so the nest always terminates.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tile_s_q     <= '0;
      tile_inner_q <= '0;
      mask_type_q  <= None;
      mask_start_q <= '0;
    end else if (accept) begin
      tile_s_q     <= (cfg_tile_s_i == '0) ? CNT_W'(1) : cfg_tile_s_i;
      tile_inner_q <= (cfg_tile_inner_i == '0) ? CNT_W'(1) : cfg_tile_inner_i;
      mask_type_q  <= cfg_mask_type_i;
      mask_start_q <= cfg_mask_start_i;
    end
  end

  // Counter nest, innermost first; each level advances on the wrap of the one below.
  ita_wrap_counter #(.Width(CNT_W)) u_count (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear_i(accept),
    .en_i   (run_beat),
    .max_i  (CountMax),
    .value_o(count_o),
    .wrap_o (count_wrap)
  );

  ita_wrap_counter #(.Width(CNT_W)) u_inner (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear_i(accept),
    .en_i   (count_wrap),
    .max_i  (tile_inner_q - CNT_W'(1)),
    .value_o(inner),
    .wrap_o (inner_wrap)
  );

  ita_wrap_counter #(.Width(CNT_W)) u_tile_x (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear_i(accept),
    .en_i   (inner_wrap),
    .max_i  (tile_s_q - CNT_W'(1)),
    .value_o(tile_x_o),
    .wrap_o (tx_wrap)
  );

  ita_wrap_counter #(.Width(CNT_W)) u_tile_y (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear_i(accept),
    .en_i   (tx_wrap),
    .max_i  (tile_s_q - CNT_W'(1)),
    .value_o(tile_y_o),
    .wrap_o (ty_wrap)
  );

  // Next-state and per-state outputs; the tile_y wrap is the final beat of the job.
  always_comb begin
    state_d   = state_q;
    step_o    = Idle;
    calc_en_o = 1'b0;
    done_o    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cfg_valid_i) state_d = StInit;
      end
      StInit: begin
        calc_en_o = 1'b1;  // lets the mask unit load its start position
        state_d   = StRun;
      end
      StRun: begin
        step_o    = QK;
        calc_en_o = out_ready_i;
        if (ty_wrap) state_d = StDone;
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign cfg_ready_o       = (state_q == StIdle);
  assign busy_o            = (state_q != StIdle);
  assign last_inner_tile_o = (state_q != StIdle) && (inner == tile_inner_q - CNT_W'(1));
  assign mask_type_o       = mask_type_q;
  assign mask_start_o      = mask_start_q;

endmodule

// File: tb/tb_ita_mask_scheduler.sv
// Self-checking bench for ita_mask_scheduler: job table plus reset and held-valid sequences.
module tb_ita_mask_scheduler;
  import ita_package::*;

  localparam int unsigned CW  = 16;
  localparam int unsigned BPT = 256;  // 64*64/16

  logic          clk, rst;
  logic          cfg_valid, cfg_ready, out_ready;
  logic [CW-1:0] cfg_tile_s, cfg_tile_inner, cfg_mask_start;
  mask_e         cfg_mask_type;
  step_e         step;
  logic          calc_en, last_inner, busy, done;
  logic [CW-1:0] count, tile_x, tile_y, mask_start;
  mask_e         mask_type;

  ita_mask_scheduler dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .cfg_valid_i      (cfg_valid),
    .cfg_ready_o      (cfg_ready),
    .cfg_tile_s_i     (cfg_tile_s),
    .cfg_tile_inner_i (cfg_tile_inner),
    .cfg_mask_type_i  (cfg_mask_type),
    .cfg_mask_start_i (cfg_mask_start),
    .out_ready_i      (out_ready),
    .step_o           (step),
    .calc_en_o        (calc_en),
    .count_o          (count),
    .tile_x_o         (tile_x),
    .tile_y_o         (tile_y),
    .last_inner_tile_o(last_inner),
    .mask_type_o      (mask_type),
    .mask_start_o     (mask_start),
    .busy_o           (busy),
    .done_o           (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int unsigned tile_s;
    int unsigned tile_inner;
    mask_e       mtype;
    int unsigned mstart;
    bit          rnd;
    int unsigned exp_beats;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [48:0] sb[$];  // {tile_y, tile_x, count, last_inner} per expected beat

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctrl"}, {step, calc_en, done, busy, cfg_ready, mask_type, mask_start},
        {Idle, 1'b0, 1'b0, 1'b0, 1'b1, None, 16'd0});
    chk({tag, "_cnt"}, {tile_y, tile_x, count, last_inner}, 49'd0);
  endtask

  function automatic bit drive_ready(input bit rnd);
    return rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  // Runs one job; with hold set, cfg_valid stays high and the inputs change to
  // the next job's config (mask_start+100, 1x1, None) while this job is busy.
  task automatic run_job(input vec_t v, input bit hold, input int abort_at,
                         output bit aborted);
    int unsigned es, ei, beats, bound;
    bit fin;
    es = (v.tile_s == 0) ? 1 : v.tile_s;
    ei = (v.tile_inner == 0) ? 1 : v.tile_inner;
    sb.delete();
    for (int ty = 0; ty < int'(es); ty++)
      for (int tx = 0; tx < int'(es); tx++)
        for (int in = 0; in < int'(ei); in++)
          for (int c = 0; c < int'(BPT); c++)
            sb.push_back({16'(ty), 16'(tx), 16'(c), in == int'(ei) - 1});

    @(negedge clk);
    cfg_tile_s     = 16'(v.tile_s);
    cfg_tile_inner = 16'(v.tile_inner);
    cfg_mask_type  = v.mtype;
    cfg_mask_start = 16'(v.mstart);
    cfg_valid      = 1'b1;
    out_ready      = drive_ready(v.rnd);
    #1;
    chk("idle_accept", {cfg_ready, busy, done}, 3'b100);

    @(negedge clk);
    if (hold) begin
      cfg_mask_start = 16'(v.mstart + 100);
      cfg_tile_s     = 16'd1;
      cfg_tile_inner = 16'd1;
      cfg_mask_type  = None;
    end else begin
      cfg_valid = 1'b0;
    end
    out_ready = drive_ready(v.rnd);
    #1;
    chk("init", {step, calc_en, busy, cfg_ready, done, mask_type, mask_start},
        {Idle, 1'b1, 1'b1, 1'b0, 1'b0, v.mtype, 16'(v.mstart)});
    chk("init_cnt", {tile_y, tile_x, count, last_inner}, sb[0]);

    beats   = 0;
    fin     = 1'b0;
    aborted = 1'b0;
    bound   = v.exp_beats * 8 + 64;
    for (int cyc = 0; cyc < int'(bound) && !fin; cyc++) begin
      @(negedge clk);
      out_ready = drive_ready(v.rnd);
      #1;
      if (done) begin
        chk("done_state", {step, calc_en, busy, cfg_ready, mask_type, mask_start},
            {Idle, 1'b0, 1'b1, 1'b0, v.mtype, 16'(v.mstart)});
        chk("beats", beats, v.exp_beats);
        chk("sb_empty", sb.size(), 0);
        fin = 1'b1;
      end else begin
        chk("run_step", {step, calc_en}, {QK, out_ready});
        if (sb.size() == 0) begin
          chk("overrun_done", done, 1'b1);
          fin = 1'b1;
        end else begin
          chk("beat", {tile_y, tile_x, count, last_inner}, sb[0]);
          if (calc_en) begin
            void'(sb.pop_front());
            beats++;
          end
          if (abort_at >= 0 && beats == unsigned'(abort_at)) begin
            aborted = 1'b1;
            fin     = 1'b1;
          end
        end
      end
    end
    if (!fin) chk("timeout_done", done, 1'b1);
  endtask

  vec_t tbl[5];
  vec_t v;
  bit   ab;
  int   done_seen;

  initial begin
    tbl[0] = '{1, 1, None,            0,  1'b0, 256};
    tbl[1] = '{2, 2, UpperTriangular, 5,  1'b0, 2048};
    tbl[2] = '{2, 1, LowerTriangular, 9,  1'b1, 1024};
    tbl[3] = '{0, 0, Strided,         3,  1'b0, 256};
    tbl[4] = '{1, 3, UpperTriangular, 40, 1'b1, 768};

    rst            = 1'b1;
    cfg_valid      = 1'b0;
    cfg_tile_s     = '0;
    cfg_tile_inner = '0;
    cfg_mask_type  = None;
    cfg_mask_start = '0;
    out_ready      = 1'b0;
    #12;
    chk_reset_vals("reset_held");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_vals("reset_released");

    for (int i = 0; i < 5; i++) run_job(tbl[i], 1'b0, -1, ab);

    // Asynchronous reset in the middle of a 2x2 job.
    v = '{2, 1, UpperTriangular, 17, 1'b0, 1024};
    run_job(v, 1'b0, 100, ab);
    chk("abort_reached", ab, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("async_reset");
    done_seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      if (done) done_seen++;
    end
    chk("no_done_in_reset", done_seen, 0);
    rst = 1'b0;
    v = '{1, 2, LowerTriangular, 4, 1'b0, 512};
    run_job(v, 1'b0, -1, ab);

    // cfg_valid held high across a job: the next config must wait for IDLE.
    v = '{1, 1, UpperTriangular, 20, 1'b0, 256};
    run_job(v, 1'b1, -1, ab);
    v = '{1, 1, None, 120, 1'b0, 256};
    run_job(v, 1'b0, -1, ab);

    @(negedge clk);
    #1;
    chk("final_idle", {done, busy, cfg_ready, step, calc_en}, {1'b0, 1'b0, 1'b1, Idle, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
